// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO count-width helper and status bundle
package fifo_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // store accepted writes; array is deliberately not reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with count, threshold flags, sticky errors, flush and optional FWFT
module fifo_flags import fifo_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 2,
  parameter int FWFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          in,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data, out_q;
  logic wr_ok, rd_ok;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign almost_empty = count <= CW'(AE_THRESH);
  assign almost_full = count >= CW'(AF_THRESH);
  fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(PW)) u_mem (
    .clk(clk),
    .we(wr_ok & ~flush),
    .waddr(wr_ptr),
    .wdata(in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  // pointers, occupancy and sticky errors; flush overrides any request on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= nxt(wr_ptr);
      if (rd_ok) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      overflow <= (wr_en & ~wr_ok) | (overflow & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  // registered read data, or in show-ahead mode the last word shown so it holds once empty
  always_ff @(posedge clk or posedge rst)
    if (rst) out_q <= '0;
    else if (FWFT != 0 ? !empty : (rd_ok & ~flush)) out_q <= rd_data;
  assign out = (FWFT != 0 && !empty) ? rd_data : out_q;
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: scoreboard bench running registered-read and show-ahead FIFOs side by side
module tb_fifo_flags;
  localparam int D = 32;
  logic clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0, clr_err = 0;
  logic [7:0] din = 0;
  logic [7:0] out0, out1;
  logic [5:0] count0, count1;
  logic empty0, full0, ae0, af0, ovf0, unf0;
  logic empty1, full1, ae1, af1, ovf1, unf1;
  logic [7:0] q[$];
  logic [7:0] exp_out0 = 0, hold1 = 0;
  logic e_ovf = 0, e_unf = 0;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  fifo_flags #(.DEPTH(D), .WIDTH(8), .AF_THRESH(28), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in(din), .wr_en(wr_en), .rd_en(rd_en),
    .out(out0), .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
    .count(count0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err));
  fifo_flags #(.DEPTH(D), .WIDTH(8), .AF_THRESH(28), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in(din), .wr_en(wr_en), .rd_en(rd_en),
    .out(out1), .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
    .count(count1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int n = q.size();
    chk("count0", 32'(count0), n);
    chk("count1", 32'(count1), n);
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("full0", 32'(full0), 32'(n == D));
    chk("full1", 32'(full1), 32'(n == D));
    chk("ae0", 32'(ae0), 32'(n <= 2));
    chk("ae1", 32'(ae1), 32'(n <= 2));
    chk("af0", 32'(af0), 32'(n >= 28));
    chk("af1", 32'(af1), 32'(n >= 28));
    chk("ovf0", 32'(ovf0), 32'(e_ovf));
    chk("ovf1", 32'(ovf1), 32'(e_ovf));
    chk("unf0", 32'(unf0), 32'(e_unf));
    chk("unf1", 32'(unf1), 32'(e_unf));
    chk("out0", 32'(out0), 32'(exp_out0));
    if (n == 0) chk("out1_hold", 32'(out1), 32'(hold1));
    else chk("out1", 32'(out1), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic ce, input logic [7:0] d);
    int n = q.size();
    logic rok, wok;
    wr_en = w; rd_en = r; flush = f; clr_err = ce; din = d;
    rok = r && n > 0;
    wok = w && (n < D || rok);
    if (n > 0) hold1 = q[0];
    @(posedge clk); #1;
    if (f) begin
      q.delete();
      e_ovf = 0;
      e_unf = 0;
    end else begin
      if (rok) exp_out0 = q.pop_front();
      if (wok) q.push_back(d);
      e_ovf = (w && !wok) || (e_ovf && !ce);
      e_unf = (r && n == 0) || (e_unf && !ce);
    end
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    check_state();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_state();
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 8'(i));
    step(1, 0, 0, 0, 8'hAA);
    for (int i = 0; i < D; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 8'(i + 100));
    step(1, 1, 0, 0, 8'h55);
    for (int i = 0; i < D; i++) step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h77);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 100; i++) step(1, i >= 3, 0, 0, 8'(i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(200 + i));
    step(1, 1, 1, 0, 8'hEE);
    step(1, 0, 0, 0, 8'h3C);
    step(1, 0, 0, 0, 8'h4D);
    step(0, 1, 0, 0, 8'h00);
    wr_en = 1; din = 8'h99;
    #2 rst = 1;
    @(posedge clk); #1;
    q.delete();
    e_ovf = 0; e_unf = 0; exp_out0 = 0; hold1 = 0;
    wr_en = 0;
    check_state();
    rst = 0;
    step(1, 0, 0, 0, 8'h12);
    step(0, 1, 0, 0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
